// File: rtl/VX_gpu_pkg.sv
//==============================================================================
// Module      : VX_gpu_pkg
// Description : Shared execute-packet types and split-state encoding used by
//               the execute splitter and its partition finder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef NUM_THREADS
`define NUM_THREADS 8
`endif

`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package VX_gpu_pkg;

  localparam int XLEN          = 32;
  localparam int UUID_WIDTH    = 44;
  localparam int NW_WIDTH      = 2;
  localparam int PC_WIDTH      = 32;
  localparam int INST_OP_BITS  = 4;
  localparam int NUM_REGS_BITS = 6;
  localparam int NT_WIDTH      = `LOG2UP(`NUM_THREADS);
  localparam int RRS_WIS_W     = 2;

  typedef logic [0:0] split_state_t;
  localparam split_state_t SPLIT_IDLE = 1'b0;
  localparam split_state_t SPLIT_BUSY = 1'b1;

  typedef struct packed {
    logic            use_pc;
    logic            use_imm;
    logic [XLEN-1:0] imm;
  } op_args_t;

  // Lane-independent fields, copied unchanged onto every partition.
  typedef struct packed {
    logic [UUID_WIDTH-1:0]    uuid;
    logic [NW_WIDTH-1:0]      wid;
    logic [PC_WIDTH-1:0]      pc;
    logic [INST_OP_BITS-1:0]  op_type;
    op_args_t                 op_args;
    logic                     wb;
    logic [NUM_REGS_BITS-1:0] rd;
    logic [NT_WIDTH-1:0]      tid;
    logic [RRS_WIS_W-1:0]     rrs_id;
  } exec_scalar_t;

  localparam int SCALAR_W = $bits(exec_scalar_t);
  // Per-lane payload: one tmask bit plus rs1..rs3 data.
  localparam int LANE_W   = 1 + 3 * XLEN;

  function automatic int part_mask_width(input int in_lanes, input int out_lanes);
    return in_lanes / out_lanes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/VX_split_pfind.sv
//==============================================================================
// Module      : VX_split_pfind
// Description : Finds the lowest set partition bit after (or at) an index and
//               reports whether it is the last set bit of the mask.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module VX_split_pfind #(
  parameter int NUM_PARTS = 4,
  parameter int PID_WIDTH = 2
) (
  input  logic [NUM_PARTS-1:0] mask,
  input  logic [PID_WIDTH-1:0] cur_idx,
  input  logic                 inclusive,
  output logic [PID_WIDTH-1:0] next_idx,
  output logic                 valid,
  output logic                 is_last
);

  always_comb begin
    next_idx = '0;
    valid    = 1'b0;
    is_last  = 1'b1;
    for (int i = 0; i < NUM_PARTS; i++) begin
      if (mask[i] && ((i > int'(cur_idx)) || (inclusive && (i == int'(cur_idx))))) begin
        if (valid) begin
          is_last = 1'b0;
        end else begin
          valid    = 1'b1;
          next_idx = PID_WIDTH'(i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vx_execute_splitter.sv
//==============================================================================
// Module      : vx_execute_splitter
// Description : Splits a wide execute packet into OUT_LANES-wide partitions.
//               Define EXEC_SPLIT_SKIP_EN to skip partitions with empty tmask.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef NUM_THREADS
`define NUM_THREADS 8
`endif

`ifndef LOG2UP
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module vx_execute_splitter
  import VX_gpu_pkg::*;
#(
  parameter  int IN_LANES  = `NUM_THREADS,
  parameter  int OUT_LANES = 4,
  localparam int NUM_PARTS = IN_LANES / OUT_LANES,
  localparam int PID_WIDTH = `LOG2UP(NUM_PARTS),
  localparam int IN_W      = SCALAR_W + IN_LANES * LANE_W,
  localparam int OUT_W     = SCALAR_W + OUT_LANES * LANE_W + PID_WIDTH + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready
);

  localparam int IW = IN_LANES * XLEN;
  localparam int OW = OUT_LANES * XLEN;
  localparam int PM_W = part_mask_width(IN_LANES, OUT_LANES);

  exec_scalar_t          in_scal;
  logic [IN_LANES-1:0]   in_tmask;
  logic [IW-1:0]         in_rs1, in_rs2, in_rs3;
  logic [PM_W-1:0]       in_pmask;

  assign {in_scal, in_tmask, in_rs1, in_rs2, in_rs3} = in_data;

`ifdef EXEC_SPLIT_SKIP_EN
  always_comb begin
    in_pmask = '0;
    for (int p = 0; p < NUM_PARTS; p++) begin
      in_pmask[p] = |in_tmask[p*OUT_LANES +: OUT_LANES];
    end
  end
`else
  assign in_pmask = '1;
`endif

  split_state_t           state_q, state_d;
  logic [PID_WIDTH-1:0]   pid_q, pid_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic [PM_W-1:0]        pmask_q, pmask_d;
  exec_scalar_t           scal_q, scal_d;
  logic [IN_LANES-1:0]    tmask_q, tmask_d;
  logic [IW-1:0]          rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;

  logic in_fire, out_fire;

  assign out_valid = (state_q == SPLIT_BUSY);
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = !out_valid || (out_fire && eop_q);
  assign in_fire   = in_valid && in_ready;

  // One finder serves both the first-partition search on load and the
  // next-partition search on advance; the two never happen in the same cycle.
  logic [PM_W-1:0]      pf_mask;
  logic [PID_WIDTH-1:0] pf_cur, pf_idx;
  logic                 pf_valid, pf_last;

  assign pf_mask = in_fire ? in_pmask : pmask_q;
  assign pf_cur  = in_fire ? '0 : pid_q;

  VX_split_pfind #(
    .NUM_PARTS (NUM_PARTS),
    .PID_WIDTH (PID_WIDTH)
  ) u_pfind (
    .mask      (pf_mask),
    .cur_idx   (pf_cur),
    .inclusive (in_fire),
    .next_idx  (pf_idx),
    .valid     (pf_valid),
    .is_last   (pf_last)
  );

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    pmask_d = pmask_q;
    scal_d  = scal_q;
    tmask_d = tmask_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    if (in_fire) begin
      state_d = SPLIT_BUSY;
      pmask_d = in_pmask;
      sop_d   = 1'b1;
      // An empty mask still yields one beat at pid 0.
      pid_d   = pf_valid ? pf_idx : '0;
      eop_d   = !pf_valid || pf_last;
      scal_d  = in_scal;
      tmask_d = in_tmask;
      rs1_d   = in_rs1;
      rs2_d   = in_rs2;
      rs3_d   = in_rs3;
    end else if (out_fire) begin
      if (eop_q) begin
        state_d = SPLIT_IDLE;
      end else begin
        pid_d = pf_idx;
        sop_d = 1'b0;
        eop_d = pf_last;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SPLIT_IDLE;
      pid_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      pmask_q <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      pmask_q <= pmask_d;
    end
  end

  always_ff @(posedge clk) begin
    scal_q  <= scal_d;
    tmask_q <= tmask_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
    rs3_q   <= rs3_d;
  end

  int                   lane_base;
  logic [OUT_LANES-1:0] out_tmask;
  logic [OW-1:0]        out_rs1, out_rs2, out_rs3;

  always_comb begin
    lane_base = int'(pid_q) * OUT_LANES;
    out_tmask = tmask_q[lane_base +: OUT_LANES];
    out_rs1   = rs1_q[lane_base*XLEN +: OW];
    out_rs2   = rs2_q[lane_base*XLEN +: OW];
    out_rs3   = rs3_q[lane_base*XLEN +: OW];
  end

  assign out_data = {scal_q, out_tmask, out_rs1, out_rs2, out_rs3, pid_q, sop_q, eop_q};

endmodule

`default_nettype wire

// File: tb/tb_vx_execute_splitter.sv
//==============================================================================
// Module      : tb_vx_execute_splitter
// Description : Directed self-checking bench for vx_execute_splitter (8 -> 2 lanes).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vx_execute_splitter;
  import VX_gpu_pkg::*;

  localparam int IN_LANES  = 8;
  localparam int OUT_LANES = 2;
  localparam int PW        = 2;
  localparam int IN_W      = SCALAR_W + IN_LANES * LANE_W;
  localparam int OUT_W     = SCALAR_W + OUT_LANES * LANE_W + PW + 2;
`ifdef EXEC_SPLIT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;

  vx_execute_splitter #(
    .IN_LANES  (IN_LANES),
    .OUT_LANES (OUT_LANES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exec_scalar_t                 o_scal;
  logic [OUT_LANES-1:0]         o_tmask;
  logic [OUT_LANES*XLEN-1:0]    o_rs1, o_rs2, o_rs3;
  logic [PW-1:0]                o_pid;
  logic                         o_sop, o_eop;

  assign {o_scal, o_tmask, o_rs1, o_rs2, o_rs3, o_pid, o_sop, o_eop} = out_data;

  function automatic exec_scalar_t mk_scal(input logic [43:0] uuid);
    exec_scalar_t s;
    s                 = '0;
    s.uuid            = uuid;
    s.wid             = 2'd1;
    s.pc              = 32'h8000_0100 + uuid[31:0];
    s.op_type         = 4'h3;
    s.op_args.use_imm = 1'b1;
    s.op_args.imm     = 32'h0000_ABCD;
    s.wb              = 1'b1;
    s.rd              = 6'd5;
    s.tid             = 3'd6;
    s.rrs_id          = 2'd2;
    return s;
  endfunction

  // Lane k of rs1/rs2/rs3 carries 0x1000_0000+k / 0x2000_0000+k / 0x3000_0000+k.
  function automatic logic [IN_W-1:0] mk_pkt(input logic [43:0] uuid, input logic [7:0] tmask);
    logic [IN_LANES*XLEN-1:0] r1, r2, r3;
    for (int k = 0; k < IN_LANES; k++) begin
      r1[k*XLEN +: XLEN] = 32'h1000_0000 + 32'(k);
      r2[k*XLEN +: XLEN] = 32'h2000_0000 + 32'(k);
      r3[k*XLEN +: XLEN] = 32'h3000_0000 + 32'(k);
    end
    return {mk_scal(uuid), tmask, r1, r2, r3};
  endfunction

  function automatic logic [63:0] exp_rs(input logic [31:0] base, input int p);
    return {base + 32'(2 * p + 1), base + 32'(2 * p)};
  endfunction

  function automatic logic [SCALAR_W+191:0] exp_data(input logic [43:0] uuid, input int p);
    return {mk_scal(uuid), exp_rs(32'h1000_0000, p), exp_rs(32'h2000_0000, p),
            exp_rs(32'h3000_0000, p)};
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_hold got valid/ready=%b exp=01", {out_valid, in_ready});
    end
    @(negedge clk); reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_release got valid/ready=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_full();
    logic [7:0] exp_c;
    @(negedge clk);
    in_valid = 1'b1; in_data = mk_pkt(44'd1, 8'hFF); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      exp_c = {1'b1, 2'(b), b == 0, b == 3, 2'b11, b == 3};
      checks++;
      if ({out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready} !== exp_c) begin
        failures++;
        $display("FAIL full_ctrl beat %0d got=%b exp=%b", b,
                 {out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready}, exp_c);
      end
      checks++;
      if ({o_scal, o_rs1, o_rs2, o_rs3} !== exp_data(44'd1, b)) begin
        failures++;
        $display("FAIL full_data beat %0d got=%h exp=%h", b,
                 {o_scal, o_rs1, o_rs2, o_rs3}, exp_data(44'd1, b));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_sparse();
    int nb, p;
    logic [7:0] exp_c;
    nb = SKIP ? 1 : 4;
    @(negedge clk);
    in_valid = 1'b1; in_data = mk_pkt(44'd4, 8'b0011_0000); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      #1;
      p = SKIP ? 2 : b;
      exp_c = {1'b1, 2'(p), b == 0, b == nb - 1, (p == 2) ? 2'b11 : 2'b00, b == nb - 1};
      checks++;
      if ({out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready} !== exp_c) begin
        failures++;
        $display("FAIL sparse_ctrl beat %0d got=%b exp=%b", b,
                 {out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready}, exp_c);
      end
      checks++;
      if ({o_scal, o_rs1, o_rs2, o_rs3} !== exp_data(44'd4, p)) begin
        failures++;
        $display("FAIL sparse_data beat %0d got=%h exp=%h", b,
                 {o_scal, o_rs1, o_rs2, o_rs3}, exp_data(44'd4, p));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sparse_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_stall();
    int  pids [7] = '{0, 1, 1, 1, 1, 2, 3};
    bit  rdy  [7] = '{1, 0, 0, 0, 1, 1, 1};
    logic [7:0] exp_c;
    @(negedge clk);
    in_valid = 1'b1; in_data = mk_pkt(44'd3, 8'hFF); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      out_ready = rdy[c];
      #1;
      exp_c = {1'b1, 2'(pids[c]), pids[c] == 0, pids[c] == 3, 2'b11, c == 6};
      checks++;
      if ({out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready} !== exp_c) begin
        failures++;
        $display("FAIL stall_ctrl cycle %0d got=%b exp=%b", c,
                 {out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready}, exp_c);
      end
      checks++;
      if ({o_scal, o_rs1, o_rs2, o_rs3} !== exp_data(44'd3, pids[c])) begin
        failures++;
        $display("FAIL stall_data cycle %0d got=%h exp=%h", c,
                 {o_scal, o_rs1, o_rs2, o_rs3}, exp_data(44'd3, pids[c]));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_c;
    logic [43:0] u;
    @(negedge clk);
    in_valid = 1'b1; in_data = mk_pkt(44'd5, 8'hFF); out_ready = 1'b1;
    @(negedge clk); in_data = mk_pkt(44'd6, 8'hFF);
    for (int b = 0; b < 8; b++) begin
      if (b == 4) in_valid = 1'b0;
      #1;
      u = (b < 4) ? 44'd5 : 44'd6;
      exp_c = {1'b1, 2'(b % 4), (b % 4) == 0, (b % 4) == 3, 2'b11, (b % 4) == 3};
      checks++;
      if ({out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready} !== exp_c) begin
        failures++;
        $display("FAIL b2b_ctrl beat %0d got=%b exp=%b", b,
                 {out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready}, exp_c);
      end
      checks++;
      if ({o_scal, o_rs1, o_rs2, o_rs3} !== exp_data(u, b % 4)) begin
        failures++;
        $display("FAIL b2b_data beat %0d got=%h exp=%h", b,
                 {o_scal, o_rs1, o_rs2, o_rs3}, exp_data(u, b % 4));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    logic [7:0] exp_c;
    nb = SKIP ? 1 : 4;
    @(negedge clk);
    in_valid = 1'b1; in_data = mk_pkt(44'd7, 8'hFF); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, o_pid} !== 3'b110) begin
      failures++;
      $display("FAIL rstmid_pre got valid/pid=%b exp=110", {out_valid, o_pid});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_async got valid/ready=%b exp=01", {out_valid, in_ready});
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = mk_pkt(44'd9, 8'h03);
    @(negedge clk); in_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      #1;
      exp_c = {1'b1, 2'(b), b == 0, b == nb - 1, (b == 0) ? 2'b11 : 2'b00, b == nb - 1};
      checks++;
      if ({out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready} !== exp_c) begin
        failures++;
        $display("FAIL rstmid_ctrl beat %0d got=%b exp=%b", b,
                 {out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready}, exp_c);
      end
      checks++;
      if (o_scal.uuid !== 44'd9) begin
        failures++;
        $display("FAIL rstmid_uuid beat %0d got=%0d exp=9", b, o_scal.uuid);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_zero_mask();
    int nb;
    logic [7:0] exp_c;
    nb = SKIP ? 1 : 4;
    @(negedge clk);
    in_valid = 1'b1; in_data = mk_pkt(44'd8, 8'h00); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      #1;
      exp_c = {1'b1, 2'(b), b == 0, b == nb - 1, 2'b00, b == nb - 1};
      checks++;
      if ({out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready} !== exp_c) begin
        failures++;
        $display("FAIL zero_ctrl beat %0d got=%b exp=%b", b,
                 {out_valid, o_pid, o_sop, o_eop, o_tmask, in_ready}, exp_c);
      end
      checks++;
      if ({o_scal, o_rs1, o_rs2, o_rs3} !== exp_data(44'd8, b)) begin
        failures++;
        $display("FAIL zero_data beat %0d got=%h exp=%h", b,
                 {o_scal, o_rs1, o_rs2, o_rs3}, exp_data(44'd8, b));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_drain got out_valid=%b exp=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_sparse();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_zero_mask();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_execute_splitter.md
VX_EXECUTE_SPLITTER -- requirements
Module: VX_execute_splitter

Interface
REQ-001 SHALL have parameter IN_LANES, default `NUM_THREADS: lane count of the incoming execute packet.
REQ-002 SHALL have parameter OUT_LANES, default 4: lane count per emitted partition; IN_LANES multiple of OUT_LANES.
REQ-003 SHALL have localparams NUM_PARTS = IN_LANES/OUT_LANES and PID_WIDTH = `LOG2UP(NUM_PARTS).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, as the interface ports below define.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 in_valid / in_data / in_ready  input/input/output  1/execute packet of IN_LANES/1  slave side: uuid, wid, tmask, PC, op_type, op_args, wb, rd, tid, rs1..rs3 data, rrs_id.
REQ-008 out_valid / out_data / out_ready  output/output/input  1/execute packet of OUT_LANES/1  master side: same fields at OUT_LANES width, plus pid, sop, eop.

Function
REQ-009 SHALL implement two states: IDLE (no packet held) and SPLIT (packet held, partitions pending).
REQ-010 SHALL drive in_ready = (state==IDLE) OR (out_valid AND out_ready AND out_data.eop).
REQ-011 On in_valid&in_ready SHALL register the packet, load the first partition index, and enter SPLIT. Latency in-fire to out_valid is 1 cycle.
REQ-012 In SPLIT SHALL assert out_valid. out_data.pid = current partition index p. tmask/rs1/rs2/rs3 = lanes [p*OUT_LANES +: OUT_LANES]. All scalar fields are copied unchanged.
REQ-013 SHALL set sop=1 only on the first emitted partition and eop=1 only on the last emitted partition of a packet.
REQ-014 SHALL hold out_data stable while out_valid&!out_ready. The partition index advances only on out fire.
REQ-015 On out fire with eop: if an input fires in the same cycle, SHALL load it with no bubble cycle; otherwise SHALL return to IDLE.
REQ-016 An input with tmask all zero SHALL produce exactly one partition: pid=0, tmask=0, sop=eop=1.
REQ-017 When NUM_PARTS==1, SHALL act as a one-stage register slice: pid=0, sop=eop=1 on every packet.
REQ-018 SHALL never drop, duplicate or reorder packets. Partitions of one packet SHALL appear in ascending pid.

Reset
REQ-019 On reset assertion, SHALL asynchronously clear state to IDLE, out_valid=0, partition index=0, and the held packet's valid. in_ready SHALL read 1 after reset.
REQ-020 Reset mid-SPLIT SHALL discard the held packet. The first packet after reset SHALL start at sop=1.

Configuration
REQ-021 Macro EXEC_SPLIT_SKIP_EN defined: SHALL skip partitions whose tmask slice is zero. First, next and last partitions are computed from a per-partition nonzero mask using a priority encoder. sop/eop mark the first and last non-empty partitions.
REQ-022 Macro undefined: SHALL emit all NUM_PARTS partitions (pid 0..NUM_PARTS-1), including empty ones. sop is on pid 0 and eop on pid NUM_PARTS-1. REQ-016 applies only when the macro is defined.

Structure
REQ-023 The split-state enum and the partition-mask helper width SHALL live in VX_gpu_pkg. op_args_t and RRS_WIS_W are reused from VX_gpu_pkg.
REQ-024 Data types SHALL be the existing execute interface instantiated with NUM_LANES=IN_LANES (slave) and NUM_LANES=OUT_LANES, PID_WIDTH=PID_WIDTH (master).
REQ-025 The next-nonzero-partition search SHALL be a single sub-module VX_split_pfind (NUM_PARTS-bit mask + current index -> next index, valid, is_last).

Verification
REQ-026 IN_LANES=8, OUT_LANES=2, tmask=8'hFF, out_ready=1 -> 4 beats pid 0,1,2,3 on consecutive cycles. sop on pid0, eop on pid3. in_ready=1 in the pid3 cycle.
REQ-027 SKIP_EN, tmask=8'b0011_0000 -> single beat pid=2, tmask=2'b11, sop=eop=1. Without SKIP_EN -> 4 beats with tmask 0,0,3,0.
REQ-028 tmask=8'hFF, out_ready low 3 cycles while pid=1 -> out_data bit-identical across the stall. Then pid 2, 3 follow. No lost or duplicate beats.
REQ-029 Two back-to-back packets (uuid 5, 6), in_valid held high -> uuid 6 pid0 immediately follows uuid 5 eop beat, with zero idle cycles.
REQ-030 Reset asserted while pid=2 pending -> out_valid=0 and in_ready=1 the same cycle. The next packet (uuid 9, tmask 8'h03) emits pid0 with sop=1.
REQ-031 tmask=8'h00 with SKIP_EN -> exactly one beat pid=0, tmask=0, sop=eop=1.
